// File: rtl/esp32_spi_byte_phy_if.sv
// Byte-stream side of the ESP32 SPI byte PHY.
// master = the PHY (produces received bytes, accepts transmit bytes),
// slave  = the protocol processor that consumes/produces the byte stream.
interface esp32_spi_byte_phy_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_load;
  logic [7:0] tx_data;
  logic       tx_empty;
  logic       tx_underrun;
  logic       idle_timeout;
  logic       frame_active;

  modport master (
    output rx_valid, rx_data, tx_empty, tx_underrun, idle_timeout, frame_active,
    input  tx_load, tx_data
  );

  modport slave (
    input  rx_valid, rx_data, tx_empty, tx_underrun, idle_timeout, frame_active,
    output tx_load, tx_data
  );
endinterface

// File: rtl/esp32_spi_byte_phy.sv
// Byte-level SPI mode-0 slave PHY (MSB first) for the ESP32 link.
// No chip select exists: a frame starts on the first SCLK rise and ends
// after IDLE_TO_CYC clk cycles without any SCLK edge.
// MISO comes from tx_shift, fed at each byte boundary from a one-deep
// holding register (or FF on underrun), so a byte loaded during byte N
// goes out during byte N+1.
module esp32_spi_byte_phy #(
  parameter int USE_SYNC    = 1,
  parameter int IDLE_TO_CYC = 54_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sclk,
  input  logic                        mosi,
  output logic                        miso,
  esp32_spi_byte_phy_if.master        bus
);

  localparam int IDLE_W = $clog2(IDLE_TO_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TO_CYC - 1);

  logic              sclk_s2_s;
  logic              mosi_s2_s;
  logic              sclk_s3_r;
  logic              rise_s;
  logic              fall_s;
  logic              edge_s;
  logic              boundary_s;
  logic              timeout_s;
  logic [7:0]        rx_byte_s;

  logic [2:0]        bit_cnt_r;
  logic [6:0]        rx_shift_r;
  logic [7:0]        rx_data_r;
  logic              rx_valid_r;
  logic              frame_active_r;
  logic [IDLE_W-1:0] idle_cnt_r;
  logic              idle_timeout_r;
  logic [7:0]        tx_shift_r;
  logic [7:0]        hold_r;
  logic              hold_full_r;
  logic              tx_underrun_r;

  generate
    if (USE_SYNC != 0) begin : g_sync
      logic sclk_s1_r;
      logic sclk_s2_r;
      logic mosi_s1_r;
      logic mosi_s2_r;

      // Two-flop synchronisers bringing the asynchronous pins into clk.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sclk_s1_r <= 1'b0;
          sclk_s2_r <= 1'b0;
          mosi_s1_r <= 1'b0;
          mosi_s2_r <= 1'b0;
        end else begin
          sclk_s1_r <= sclk;
          sclk_s2_r <= sclk_s1_r;
          mosi_s1_r <= mosi;
          mosi_s2_r <= mosi_s1_r;
        end
      end

      assign sclk_s2_s = sclk_s2_r;
      assign mosi_s2_s = mosi_s2_r;
    end else begin : g_nosync
      assign sclk_s2_s = sclk;
      assign mosi_s2_s = mosi;
    end
  endgenerate

  // Edge-detect delay flop on the (synchronised) SCLK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s3_r <= 1'b0;
    end else begin
      sclk_s3_r <= sclk_s2_s;
    end
  end

  // SCLK edges, byte boundary and idle-timeout qualifiers.
  always_comb begin
    rise_s     = sclk_s2_s & ~sclk_s3_r;
    fall_s     = ~sclk_s2_s & sclk_s3_r;
    edge_s     = rise_s | fall_s;
    boundary_s = rise_s & (bit_cnt_r == 3'd7);
    timeout_s  = frame_active_r & ~edge_s & (idle_cnt_r == IDLE_LAST);
    rx_byte_s  = {rx_shift_r, mosi_s2_s};
  end

  // Receive path: bit counting, byte assembly, frame tracking and idle timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r      <= 3'd0;
      rx_shift_r     <= 7'd0;
      rx_data_r      <= 8'h00;
      rx_valid_r     <= 1'b0;
      frame_active_r <= 1'b0;
      idle_cnt_r     <= '0;
      idle_timeout_r <= 1'b0;
    end else if (timeout_s) begin
      // Partial byte is dropped by restarting the bit count.
      bit_cnt_r      <= 3'd0;
      frame_active_r <= 1'b0;
      idle_cnt_r     <= '0;
      idle_timeout_r <= 1'b1;
      rx_valid_r     <= 1'b0;
    end else begin
      idle_timeout_r <= 1'b0;
      rx_valid_r     <= boundary_s;
      if (boundary_s) begin
        rx_data_r <= rx_byte_s;
      end
      if (rise_s) begin
        rx_shift_r     <= rx_byte_s[6:0];
        bit_cnt_r      <= bit_cnt_r + 3'd1;
        frame_active_r <= 1'b1;
      end
      if (edge_s) begin
        idle_cnt_r <= '0;
      end else if (frame_active_r) begin
        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
      end else begin
        idle_cnt_r <= '0;
      end
    end
  end

  // Transmit path: holding register, boundary reload/bypass, MISO shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_r    <= 8'hFF;
      hold_r        <= 8'h00;
      hold_full_r   <= 1'b0;
      tx_underrun_r <= 1'b0;
    end else if (timeout_s) begin
      // Frame over: forget pending data, any tx_load this cycle is dropped.
      tx_shift_r    <= 8'hFF;
      hold_full_r   <= 1'b0;
      tx_underrun_r <= 1'b0;
    end else if (boundary_s) begin
      if (hold_full_r) begin
        tx_shift_r    <= hold_r;
        tx_underrun_r <= 1'b0;
        if (bus.tx_load) begin
          hold_r <= bus.tx_data;
        end else begin
          hold_full_r <= 1'b0;
        end
      end else if (bus.tx_load) begin
        // Late load lands directly in the shifter; hold stays empty.
        tx_shift_r    <= bus.tx_data;
        tx_underrun_r <= 1'b0;
      end else begin
        tx_shift_r    <= 8'hFF;
        tx_underrun_r <= 1'b1;
      end
    end else begin
      tx_underrun_r <= 1'b0;
      // The fall right after a boundary keeps the freshly loaded MSB on MISO.
      if (fall_s && (bit_cnt_r != 3'd0)) begin
        tx_shift_r <= {tx_shift_r[6:0], 1'b1};
      end
      if (bus.tx_load) begin
        hold_r      <= bus.tx_data;
        hold_full_r <= 1'b1;
      end
    end
  end

  assign miso             = tx_shift_r[7];
  assign bus.rx_valid     = rx_valid_r;
  assign bus.rx_data      = rx_data_r;
  assign bus.tx_empty     = ~hold_full_r;
  assign bus.tx_underrun  = tx_underrun_r;
  assign bus.idle_timeout = idle_timeout_r;
  assign bus.frame_active = frame_active_r;

endmodule

// File: tb/tb_esp32_spi_byte_phy.sv
// Directed bench for esp32_spi_byte_phy with USE_SYNC=1, SCLK period 20 clk.
module tb_esp32_spi_byte_phy;

  localparam int IDLE = 40;

  logic clk;
  logic rst_n;
  logic sclk;
  logic mosi;
  logic miso;

  esp32_spi_byte_phy_if bus_if ();

  esp32_spi_byte_phy #(.USE_SYNC(1), .IDLE_TO_CYC(IDLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso),
    .bus   (bus_if.master)
  );

  int errors = 0;
  int checks = 0;

  // Event counters written only by the monitor.
  int         rx_cnt = 0;
  int         ur_cnt = 0;
  int         ur_with_rx = 0;
  int         to_cnt = 0;
  logic [7:0] rx_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: sample pulses on the falling clk edge.
  always @(negedge clk) begin
    if (bus_if.rx_valid === 1'b1) begin
      rx_cnt++;
      rx_q.push_back(bus_if.rx_data);
    end
    if (bus_if.tx_underrun === 1'b1) begin
      ur_cnt++;
      if (bus_if.rx_valid === 1'b1) ur_with_rx++;
    end
    if (bus_if.idle_timeout === 1'b1) to_cnt++;
  end

  task automatic load_byte(input logic [7:0] v);
    bus_if.tx_data = v;
    bus_if.tx_load = 1'b1;
    @(negedge clk);
    bus_if.tx_load = 1'b0;
  endtask

  // Master side: clock nbits of d (MSB first), returning sampled MISO bits.
  task automatic send_bits(input logic [7:0] d, input int nbits, output logic [7:0] m);
    m = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = d[i];
      repeat (10) @(negedge clk);
      m[i] = miso;
      sclk = 1'b1;
      repeat (10) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame();
    repeat (IDLE + 20) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL reset_miso got=%b exp=1", miso); end
    checks++; if (bus_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", bus_if.rx_valid); end
    checks++; if (bus_if.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", bus_if.rx_data); end
    checks++; if (bus_if.tx_empty !== 1'b1) begin errors++; $display("FAIL reset_tx_empty got=%b exp=1", bus_if.tx_empty); end
    checks++; if (bus_if.tx_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", bus_if.tx_underrun); end
    checks++; if (bus_if.idle_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", bus_if.idle_timeout); end
    checks++; if (bus_if.frame_active !== 1'b0) begin errors++; $display("FAIL reset_frame_active got=%b exp=0", bus_if.frame_active); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rx_basic();
    int n0, u0;
    logic [7:0] m1, m2;
    n0 = rx_cnt; u0 = ur_cnt;
    send_bits(8'hA5, 8, m1);
    send_bits(8'h3C, 8, m2);
    repeat (2) @(negedge clk);
    checks++; if (rx_cnt - n0 !== 2) begin errors++; $display("FAIL rx_basic_count got=%0d exp=2", rx_cnt - n0); end
    checks++; if (rx_q[n0] !== 8'hA5) begin errors++; $display("FAIL rx_basic_byte0 got=%h exp=a5", rx_q[n0]); end
    checks++; if (rx_q[n0+1] !== 8'h3C) begin errors++; $display("FAIL rx_basic_byte1 got=%h exp=3c", rx_q[n0+1]); end
    checks++; if (m1 !== 8'hFF) begin errors++; $display("FAIL rx_basic_miso0 got=%h exp=ff", m1); end
    checks++; if (m2 !== 8'hFF) begin errors++; $display("FAIL rx_basic_miso1 got=%h exp=ff", m2); end
    checks++; if (ur_cnt - u0 !== 2) begin errors++; $display("FAIL rx_basic_underrun got=%0d exp=2", ur_cnt - u0); end
    checks++; if (ur_with_rx !== ur_cnt) begin errors++; $display("FAIL rx_basic_underrun_align got=%0d exp=%0d", ur_with_rx, ur_cnt); end
    end_frame();
    checks++; if (bus_if.frame_active !== 1'b0) begin errors++; $display("FAIL rx_basic_frame_end got=%b exp=0", bus_if.frame_active); end
  endtask

  task automatic test_tx_pipeline();
    int u0;
    logic [7:0] m1, m2, m3;
    u0 = ur_cnt;
    load_byte(8'h81);
    checks++; if (bus_if.tx_empty !== 1'b0) begin errors++; $display("FAIL txp_empty_after_load got=%b exp=0", bus_if.tx_empty); end
    send_bits(8'h00, 8, m1);
    load_byte(8'h7E);
    send_bits(8'h00, 8, m2);
    repeat (2) @(negedge clk);
    checks++; if (ur_cnt - u0 !== 0) begin errors++; $display("FAIL txp_underrun_early got=%0d exp=0", ur_cnt - u0); end
    send_bits(8'h00, 8, m3);
    repeat (2) @(negedge clk);
    checks++; if (m1 !== 8'hFF) begin errors++; $display("FAIL txp_miso0 got=%h exp=ff", m1); end
    checks++; if (m2 !== 8'h81) begin errors++; $display("FAIL txp_miso1 got=%h exp=81", m2); end
    checks++; if (m3 !== 8'h7E) begin errors++; $display("FAIL txp_miso2 got=%h exp=7e", m3); end
    checks++; if (ur_cnt - u0 !== 1) begin errors++; $display("FAIL txp_underrun_third got=%0d exp=1", ur_cnt - u0); end
    checks++; if (bus_if.tx_empty !== 1'b1) begin errors++; $display("FAIL txp_empty_end got=%b exp=1", bus_if.tx_empty); end
    end_frame();
  endtask

  task automatic test_idle_timeout();
    int n0, t0;
    logic [7:0] m;
    send_bits(8'hF8, 5, m);
    n0 = rx_cnt; t0 = to_cnt;
    checks++; if (bus_if.frame_active !== 1'b1) begin errors++; $display("FAIL idle_frame_on got=%b exp=1", bus_if.frame_active); end
    repeat (IDLE - 10) @(negedge clk);
    checks++; if (to_cnt - t0 !== 0) begin errors++; $display("FAIL idle_too_early got=%0d exp=0", to_cnt - t0); end
    repeat (30) @(negedge clk);
    checks++; if (to_cnt - t0 !== 1) begin errors++; $display("FAIL idle_timeout_count got=%0d exp=1", to_cnt - t0); end
    checks++; if (rx_cnt - n0 !== 0) begin errors++; $display("FAIL idle_no_rx got=%0d exp=0", rx_cnt - n0); end
    checks++; if (bus_if.frame_active !== 1'b0) begin errors++; $display("FAIL idle_frame_off got=%b exp=0", bus_if.frame_active); end
    n0 = rx_cnt;
    send_bits(8'h55, 8, m);
    repeat (2) @(negedge clk);
    checks++; if (rx_cnt - n0 !== 1) begin errors++; $display("FAIL idle_resync_count got=%0d exp=1", rx_cnt - n0); end
    checks++; if (bus_if.rx_data !== 8'h55) begin errors++; $display("FAIL idle_resync_data got=%h exp=55", bus_if.rx_data); end
    end_frame();
  endtask

  task automatic test_bypass();
    int u0;
    logic [7:0] m1, m2;
    u0 = ur_cnt;
    send_bits(8'h0F, 7, m1);
    // 8th bit by hand: the boundary posedge is the third one after the rise.
    mosi = 1'b1;
    repeat (10) @(negedge clk);
    sclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_if.tx_data = 8'h11;
    bus_if.tx_load = 1'b1;
    @(negedge clk);
    bus_if.tx_load = 1'b0;
    checks++; if (bus_if.tx_empty !== 1'b1) begin errors++; $display("FAIL bypass_empty got=%b exp=1", bus_if.tx_empty); end
    repeat (7) @(negedge clk);
    sclk = 1'b0;
    checks++; if (ur_cnt - u0 !== 0) begin errors++; $display("FAIL bypass_no_underrun got=%0d exp=0", ur_cnt - u0); end
    checks++; if (bus_if.rx_data !== 8'h0F) begin errors++; $display("FAIL bypass_rx got=%h exp=0f", bus_if.rx_data); end
    send_bits(8'h00, 8, m2);
    checks++; if (m2 !== 8'h11) begin errors++; $display("FAIL bypass_miso got=%h exp=11", m2); end
    end_frame();
  endtask

  task automatic test_overwrite();
    int u0;
    logic [7:0] m1, m2;
    u0 = ur_cnt;
    load_byte(8'h22);
    @(negedge clk);
    load_byte(8'h33);
    send_bits(8'h00, 8, m1);
    repeat (2) @(negedge clk);
    checks++; if (ur_cnt - u0 !== 0) begin errors++; $display("FAIL ovw_no_underrun got=%0d exp=0", ur_cnt - u0); end
    checks++; if (bus_if.tx_empty !== 1'b1) begin errors++; $display("FAIL ovw_empty got=%b exp=1", bus_if.tx_empty); end
    send_bits(8'h00, 8, m2);
    checks++; if (m1 !== 8'hFF) begin errors++; $display("FAIL ovw_miso0 got=%h exp=ff", m1); end
    checks++; if (m2 !== 8'h33) begin errors++; $display("FAIL ovw_miso1 got=%h exp=33", m2); end
    end_frame();
  endtask

  task automatic test_reset_midbyte();
    int n0;
    logic [7:0] m;
    load_byte(8'hAB);
    send_bits(8'hF0, 4, m);
    checks++; if (bus_if.tx_empty !== 1'b0) begin errors++; $display("FAIL rstm_pre_empty got=%b exp=0", bus_if.tx_empty); end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL rstm_miso got=%b exp=1", miso); end
    checks++; if (bus_if.rx_data !== 8'h00) begin errors++; $display("FAIL rstm_rx_data got=%h exp=00", bus_if.rx_data); end
    checks++; if (bus_if.tx_empty !== 1'b1) begin errors++; $display("FAIL rstm_tx_empty got=%b exp=1", bus_if.tx_empty); end
    checks++; if (bus_if.frame_active !== 1'b0) begin errors++; $display("FAIL rstm_frame got=%b exp=0", bus_if.frame_active); end
    checks++; if (bus_if.rx_valid !== 1'b0) begin errors++; $display("FAIL rstm_rx_valid got=%b exp=0", bus_if.rx_valid); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n0 = rx_cnt;
    send_bits(8'hC3, 8, m);
    repeat (2) @(negedge clk);
    checks++; if (rx_cnt - n0 !== 1) begin errors++; $display("FAIL rstm_count got=%0d exp=1", rx_cnt - n0); end
    checks++; if (bus_if.rx_data !== 8'hC3) begin errors++; $display("FAIL rstm_data got=%h exp=c3", bus_if.rx_data); end
    checks++; if (m !== 8'hFF) begin errors++; $display("FAIL rstm_miso_byte got=%h exp=ff", m); end
    end_frame();
  endtask

  initial begin
    rst_n = 1'b0;
    sclk = 1'b0;
    mosi = 1'b0;
    bus_if.tx_load = 1'b0;
    bus_if.tx_data = 8'h00;
    test_reset();
    test_rx_basic();
    test_tx_pipeline();
    test_idle_timeout();
    test_bypass();
    test_overwrite();
    test_reset_midbyte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/esp32_spi_byte_phy.md
Name: esp32_spi_byte_phy

Overview:
- Byte-level SPI slave PHY for the ESP32 link; sits directly upstream of the protocol processor, between the sclk/mosi/miso pins and the protocol's byte stream.
- Samples the asynchronous SPI pins into the clk domain, deserialises MOSI into bytes and serialises MISO from a one-deep transmit holding register.
- There is no chip-select pin, so frame boundaries come from an SCLK idle timeout.
- SPI mode 0, MSB first.

Parameters:
- USE_SYNC, 1: 1 = 2-FF synchronisers on sclk and mosi; 0 = pins already synchronous to clk (edge-detect flop only).
- IDLE_TO_CYC, 54_000: clk cycles with no SCLK edge, while frame_active, that end the frame (1 ms at 54 MHz). Must be >= 2.

Ports:
- clk  in  1  system clock, 54 MHz
- rst_n  in  1  asynchronous active-low reset
- sclk  in  1  SPI clock from ESP32, idle low
- mosi  in  1  SPI data in
- miso  out  1  SPI data out
- rx_valid  out  1  one-clk pulse: rx_data holds a completed byte
- rx_data  out  8  last received byte; stable until the next rx_valid
- tx_load  in  1  one-clk strobe: write tx_data into the holding register
- tx_data  in  8  next byte to transmit
- tx_empty  out  1  holding register empty
- tx_underrun  out  1  one-clk pulse: byte boundary reached with holding register empty
- idle_timeout  out  1  one-clk pulse: frame ended by idle timeout
- frame_active  out  1  high from the first SCLK rise until idle timeout

Behaviour:
- Reset values: miso=1, rx_valid=0, rx_data=00, tx_empty=1, tx_underrun=0, idle_timeout=0, frame_active=0.
- Internal reset values: bit_cnt=0, tx_shift=FF, idle_cnt=0.
- Reset asserted mid-byte aborts the byte; all state returns to reset values.
- Sync chain:
  - USE_SYNC=1: s1 -> s2 -> s3 flops on sclk; s1 -> s2 on mosi.
  - rise = s2 & ~s3; fall = ~s2 & s3; mosi sample = mosi s2.
  - USE_SYNC=0: s2 is the raw pin and only s3 is kept.
  - SCLK high and low phases must each be >= 3 clk (USE_SYNC=1) or >= 1 clk (USE_SYNC=0); otherwise behaviour is undefined.
- Rise handling:
  - On each rise: rx_shift <= {rx_shift[6:0], mosi_s}; bit_cnt increments mod 8; frame_active <= 1.
  - On the rise where bit_cnt==7: rx_data <= completed byte; rx_valid high for exactly the following clk.
  - Latency from the pin: rx_valid is high 3 clk after the first posedge that samples the 8th SCLK rise (USE_SYNC=1), or 1 clk after it (USE_SYNC=0).
- Byte boundary (same clock as the rx_data update):
  - If tx hold is full: tx_shift <= hold; hold becomes empty.
  - If tx hold is empty: tx_shift <= FF and tx_underrun pulses with rx_valid.
- Bypass: tx_load in the boundary cycle with hold empty loads tx_data straight into tx_shift. No underrun; hold stays empty.
- Fall handling:
  - A fall with bit_cnt in 1..7 shifts tx_shift left, filling with 1.
  - A fall with bit_cnt==0 does nothing, so the MSB loaded at the boundary remains presented.
- miso = tx_shift[7], registered. Because of the shift-register pipeline, the byte loaded before byte N completes is transmitted during byte N+1.
- TX hold register:
  - tx_load with hold full overwrites the hold; last write wins and no error is flagged.
  - tx_empty = ~hold_full.
  - tx_load in the same clk as a boundary with hold full: the old hold moves to tx_shift and the new byte fills the hold, so hold stays full.
- Idle counter:
  - Width $clog2(IDLE_TO_CYC+1).
  - Cleared on any rise or fall.
  - Increments each clk while frame_active and no edge occurs; holds at 0 when frame_active=0.
- Idle timeout, on the clk where idle_cnt==IDLE_TO_CYC-1 with no edge:
  - idle_timeout pulses.
  - Cleared: frame_active, bit_cnt, idle_cnt.
  - A partial rx byte is discarded with no rx_valid.
  - tx_shift <= FF, hold is discarded (tx_empty=1), no underrun.
- Simultaneous edge and timeout: the edge wins, the counter clears and no timeout fires.
- tx_load during a timeout clk is discarded.
- First byte of a frame always shifts out FF.

Test Plan:
- USE_SYNC=1, SCLK period 20 clk; send A5 then 3C, no tx_load -> rx_valid pulses twice, rx_data A5 then 3C; miso all 1s; tx_underrun pulses with each rx_valid.
- tx_load 81 before byte 1 ends, tx_load 7E before byte 2 ends; clock 3 bytes -> MISO bytes FF, 81, 7E; tx_underrun only at the 3rd boundary.
- Clock 5 bits, then stall IDLE_TO_CYC clk -> idle_timeout pulses once, no rx_valid, frame_active=0; next 8 bits 55 -> rx_valid with 55.
- tx_load 11 in the exact boundary clk with hold empty -> no underrun, next MISO byte 11, tx_empty stays 1.
- Two tx_loads (22 then 33) before a boundary -> next MISO byte 33.
- Assert rst_n low after 4 bits, release, send C3 -> rx_data C3, miso=1 during reset, all outputs at reset values during reset.
